// File: rtl/pwm_servo_multi.sv
// Multi-channel servo PWM with a shared period counter, per-channel slew-limited
// duty ramping and period-aligned shadow registers for glitch-free updates.
module pwm_servo_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP   = 1,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_cs,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  input  logic              s_read,
  output logic [31:0]       s_readdata,
  output logic [NUM_CH-1:0] pwm
);

  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  divider_q, divider_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [NUM_CH-1:0] enable_active_q, enable_active_d;
  logic [NUM_CH-1:0] loaded_q, loaded_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [CNT_W-1:0]  target_q [NUM_CH];
  logic [CNT_W-1:0]  target_d [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  logic [CNT_W-1:0]  duty_d   [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [31:0]       readdata_q, readdata_d;
  logic [NUM_CH-1:0] done;
  logic              wr_en, rd_en, period_end, ramp_tick;
  logic [CNT_W:0]    up_sum, down_floor;

  always_comb begin
    wr_en      = s_cs & s_write;
    rd_en      = s_cs & s_read;
    period_end = (tick_q >= period_q);
    ramp_tick  = (presc_q == divider_q);

    period_d        = period_q;
    divider_d       = divider_q;
    enable_d        = enable_q;
    enable_active_d = period_end ? enable_q : enable_active_q;
    tick_d          = period_end ? '0 : tick_q + CNT_W'(1);
    presc_d         = ramp_tick ? '0 : presc_q + CNT_W'(1);

    if (wr_en && s_address == ADDR_W'(0)) period_d = s_writedata[CNT_W-1:0];
    if (wr_en && s_address == ADDR_W'(1)) begin
      divider_d = s_writedata[CNT_W-1:0];
      presc_d   = '0;
    end
    if (wr_en && s_address == ADDR_W'(2)) enable_d = s_writedata[NUM_CH-1:0];

    loaded_d   = loaded_q;
    pwm_d      = '0;
    done       = '0;
    up_sum     = '0;
    down_floor = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      target_d[c] = target_q[c];
      duty_d[c]   = duty_q[c];
      shadow_d[c] = shadow_q[c];
      done[c]     = (duty_q[c] == target_q[c]);

      // Ramp against the registered target, so a same-cycle TARGET write only
      // steers the following ramp tick. One extra bit keeps the clamp exact.
      up_sum     = {1'b0, duty_q[c]} + (CNT_W+1)'(STEP);
      down_floor = {1'b0, target_q[c]} + (CNT_W+1)'(STEP);
      if (ramp_tick) begin
        if (duty_q[c] < target_q[c])
          duty_d[c] = (up_sum > {1'b0, target_q[c]}) ? target_q[c] : up_sum[CNT_W-1:0];
        else if (duty_q[c] > target_q[c])
          duty_d[c] = ({1'b0, duty_q[c]} < down_floor) ? target_q[c]
                                                       : duty_q[c] - CNT_W'(STEP);
      end

      if (wr_en && s_address == ADDR_W'(4 + 2*c)) begin
        target_d[c] = s_writedata[CNT_W-1:0];
        loaded_d[c] = 1'b1;
        if (!loaded_q[c]) duty_d[c] = s_writedata[CNT_W-1:0];
      end

      if (period_end) shadow_d[c] = duty_q[c];
      pwm_d[c] = enable_active_q[c] & (period_q != '0) & (tick_q < shadow_q[c]);
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      if (s_address == ADDR_W'(0)) readdata_d = 32'(period_q);
      if (s_address == ADDR_W'(1)) readdata_d = 32'(divider_q);
      if (s_address == ADDR_W'(2)) readdata_d = 32'(enable_q);
      if (s_address == ADDR_W'(3)) readdata_d = 32'(done);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (s_address == ADDR_W'(4 + 2*c)) readdata_d = 32'(target_q[c]);
        if (s_address == ADDR_W'(5 + 2*c)) readdata_d = 32'(duty_q[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_q        <= '0;
      divider_q       <= '0;
      tick_q          <= '0;
      presc_q         <= '0;
      enable_q        <= '0;
      enable_active_q <= '0;
      loaded_q        <= '0;
      pwm_q           <= '0;
      readdata_q      <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        target_q[c] <= '0;
        duty_q[c]   <= '0;
        shadow_q[c] <= '0;
      end
    end else begin
      period_q        <= period_d;
      divider_q       <= divider_d;
      tick_q          <= tick_d;
      presc_q         <= presc_d;
      enable_q        <= enable_d;
      enable_active_q <= enable_active_d;
      loaded_q        <= loaded_d;
      pwm_q           <= pwm_d;
      readdata_q      <= readdata_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        target_q[c] <= target_d[c];
        duty_q[c]   <= duty_d[c];
        shadow_q[c] <= shadow_d[c];
      end
    end
  end

  assign s_readdata = readdata_q;
  assign pwm        = pwm_q;

endmodule

// File: tb/tb_pwm_servo_multi.sv
// Self-checking bench for pwm_servo_multi: register map table, ramp timing,
// glitch-free updates, multi-channel widths, boundaries and mid-ramp reset.
module tb_pwm_servo_multi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_cs = 1'b0, s_write = 1'b0, s_read = 1'b0;
  logic [3:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [3:0]  pwm;

  logic        b_cs = 1'b0, b_write = 1'b0, b_read = 1'b0;
  logic [2:0]  b_address = '0;
  logic [31:0] b_writedata = '0;
  logic [31:0] b_readdata;
  logic [0:0]  pwm4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_servo_multi #(.NUM_CH(4), .CNT_W(32), .STEP(1), .ADDR_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .s_cs(s_cs), .s_address(s_address),
    .s_write(s_write), .s_writedata(s_writedata), .s_read(s_read),
    .s_readdata(s_readdata), .pwm(pwm)
  );

  pwm_servo_multi #(.NUM_CH(1), .CNT_W(32), .STEP(4), .ADDR_W(3)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .s_cs(b_cs), .s_address(b_address),
    .s_write(b_write), .s_writedata(b_writedata), .s_read(b_read),
    .s_readdata(b_readdata), .pwm(pwm4)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    s_cs = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_cs = 1'b0; s_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    s_cs = 1'b1; s_read = 1'b1; s_address = a;
    e.name = nm; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, s_readdata, e.exp);
    s_cs = 1'b0; s_read = 1'b0;
  endtask

  task automatic wr4(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    b_cs = 1'b1; b_write = 1'b1; b_address = a; b_writedata = d;
    @(negedge clk);
    b_cs = 1'b0; b_write = 1'b0;
  endtask

  task automatic rd4(input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    b_cs = 1'b1; b_read = 1'b1; b_address = a;
    @(posedge clk);
    #1;
    check(nm, b_readdata, exp);
    b_cs = 1'b0; b_read = 1'b0;
  endtask

  task automatic wait_level(input int ch, input bit lvl, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pwm[ch] == lvl) begin ok = 1'b1; break; end
    end
    if (!ok) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Current sample is assumed to be at lvl; counts samples until it changes.
  task automatic count_level(input int ch, input bit lvl, output int n);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pwm[ch] != lvl) break;
      n++;
    end
  endtask

  // Reads DUTY[0] every cycle and checks step direction, spacing and count.
  task automatic poll_ramp(input int dir, input int n_steps, input int final_v,
                           input int start_v, input string nm);
    int prev, cur, changes, last_cyc;
    @(negedge clk);
    s_cs = 1'b1; s_read = 1'b1; s_address = 4'd5;
    @(posedge clk);
    #1;
    prev = int'(s_readdata);
    check({nm, "_start"}, prev, start_v);
    changes = 0; last_cyc = 0;
    for (int cyc = 1; cyc < 120; cyc++) begin
      @(posedge clk);
      #1;
      cur = int'(s_readdata);
      if (cur != prev) begin
        check({nm, "_step"}, cur, prev + dir);
        if (changes > 0) check({nm, "_interval"}, cyc - last_cyc, 10);
        changes++;
        last_cyc = cyc;
        prev = cur;
      end
    end
    s_cs = 1'b0; s_read = 1'b0;
    check({nm, "_nsteps"}, changes, n_steps);
    check({nm, "_final"}, prev, final_v);
  endtask

  initial begin
    int n;
    int cnt [4];

    vecs.push_back('{1'b0, 4'd0,  32'd0,    "rst_period"});
    vecs.push_back('{1'b0, 4'd1,  32'd0,    "rst_divider"});
    vecs.push_back('{1'b0, 4'd2,  32'd0,    "rst_enable"});
    vecs.push_back('{1'b0, 4'd3,  32'hF,    "rst_status_all_done"});
    vecs.push_back('{1'b0, 4'd4,  32'd0,    "rst_target0"});
    vecs.push_back('{1'b0, 4'd5,  32'd0,    "rst_duty0"});
    vecs.push_back('{1'b0, 4'd11, 32'd0,    "rst_duty3"});
    vecs.push_back('{1'b0, 4'd15, 32'd0,    "rst_unmapped15"});
    vecs.push_back('{1'b1, 4'd0,  32'd999,  ""});
    vecs.push_back('{1'b0, 4'd0,  32'd999,  "period_rw"});
    vecs.push_back('{1'b1, 4'd3,  32'd0,    ""});
    vecs.push_back('{1'b0, 4'd3,  32'hF,    "status_write_ignored"});
    vecs.push_back('{1'b1, 4'd15, 32'd123,  ""});
    vecs.push_back('{1'b0, 4'd15, 32'd0,    "unmapped_read_zero"});
    vecs.push_back('{1'b1, 4'd2,  32'h1F,   ""});
    vecs.push_back('{1'b0, 4'd2,  32'hF,    "enable_upper_bits_zero"});
    vecs.push_back('{1'b1, 4'd2,  32'h1,    ""});
    vecs.push_back('{1'b0, 4'd2,  32'h1,    "enable_rw"});
    vecs.push_back('{1'b1, 4'd4,  32'd250,  ""});
    vecs.push_back('{1'b0, 4'd4,  32'd250,  "target0_rw"});
    vecs.push_back('{1'b0, 4'd5,  32'd250,  "duty0_preload"});
    vecs.push_back('{1'b0, 4'd3,  32'hF,    "status_after_preload"});
    vecs.push_back('{1'b1, 4'd5,  32'd7,    ""});
    vecs.push_back('{1'b0, 4'd5,  32'd250,  "duty_write_ignored"});

    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // Read latency and read/write collision.
    rd(4'd1, 32'd0, "lat_prev_read");
    @(negedge clk);
    s_cs = 1'b1; s_read = 1'b1; s_address = 4'd0;
    #1 check("lat_not_before_edge", s_readdata, 32'd0);
    @(posedge clk);
    #1 check("lat_one_cycle", s_readdata, 32'd999);
    s_cs = 1'b0; s_read = 1'b0;
    @(negedge clk);
    check("readdata_holds", s_readdata, 32'd999);
    @(negedge clk);
    s_cs = 1'b1; s_read = 1'b1; s_write = 1'b1; s_address = 4'd0; s_writedata = 32'd500;
    @(posedge clk);
    #1 check("rw_collision_old", s_readdata, 32'd999);
    s_cs = 1'b0; s_read = 1'b0; s_write = 1'b0;
    rd(4'd0, 32'd500, "rw_collision_new");
    wr(4'd0, 32'd999);

    // STEP=4 instance: clamped single steps.
    wr4(3'd4, 32'd100);
    rd4(3'd5, 32'd100, "s4_preload");
    wr4(3'd4, 32'd103);
    repeat (5) @(negedge clk);
    rd4(3'd5, 32'd103, "s4_clamp_up");
    wr4(3'd4, 32'd110);
    repeat (5) @(negedge clk);
    rd4(3'd5, 32'd110, "s4_multi_up");
    wr4(3'd4, 32'd100);
    repeat (5) @(negedge clk);
    rd4(3'd5, 32'd100, "s4_clamp_down");

    // Preloaded pulse on ch0.
    wait_level(0, 1'b0, "pre_low");
    wait_level(0, 1'b1, "pre_high");
    count_level(0, 1'b1, n);
    check("preload_high_250", n, 250);
    count_level(0, 1'b0, n);
    check("preload_low_750", n, 750);

    // Ramp up then down.
    wr(4'd1, 32'd9);
    wr(4'd4, 32'd255);
    rd(4'd3, 32'hE, "status_ramping");
    poll_ramp(1, 5, 255, 250, "ramp_up");
    rd(4'd3, 32'hF, "status_ramp_done");
    wr(4'd1, 32'd9);
    wr(4'd4, 32'd252);
    poll_ramp(-1, 3, 252, 255, "ramp_down");

    // Glitch-free mid-pulse TARGET change on ch1.
    wr(4'd1, 32'd0);
    wr(4'd2, 32'h3);
    wr(4'd6, 32'd300);
    wait_level(1, 1'b0, "gl_low");
    wait_level(1, 1'b1, "gl_high");
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      if (n == 100) begin
        s_cs = 1'b1; s_write = 1'b1; s_address = 4'd6; s_writedata = 32'd600;
      end else if (n == 101) begin
        s_cs = 1'b0; s_write = 1'b0;
      end
      @(negedge clk);
      if (!pwm[1]) break;
      n++;
    end
    s_cs = 1'b0; s_write = 1'b0;
    check("glitch_inflight_300", n, 300);
    count_level(1, 1'b0, n);
    check("glitch_low_700", n, 700);
    count_level(1, 1'b1, n);
    check("glitch_next_600", n, 600);

    // Multi-channel widths and enable masking.
    wr(4'd4, 32'd100);
    wr(4'd6, 32'd200);
    wr(4'd8, 32'd300);
    wr(4'd10, 32'd400);
    wr(4'd2, 32'hF);
    repeat (2200) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      wait_level(0, 1'b0, "mc_low");
      wait_level(0, 1'b1, "mc_high");
      check(pass == 0 ? "mc_aligned_F" : "mc_aligned_B", 32'(pwm), pass == 0 ? 32'hF : 32'hB);
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int i = 0; i < 1000; i++) begin
        if (i > 0) @(negedge clk);
        for (int c = 0; c < 4; c++) cnt[c] += int'(pwm[c]);
      end
      check("mc_w0", cnt[0], 100);
      check("mc_w1", cnt[1], 200);
      check("mc_w2", cnt[2], pass == 0 ? 300 : 0);
      check("mc_w3", cnt[3], 400);
      if (pass == 0) wr(4'd2, 32'hB);
    end

    // Constant high when shadow exceeds PERIOD, then PERIOD=0.
    wr(4'd2, 32'hF);
    wr(4'd10, 32'd1000);
    repeat (2200) @(negedge clk);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      n += int'(pwm[3]);
    end
    check("const_high", n, 1100);
    wr(4'd0, 32'd0);
    repeat (3) @(negedge clk);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm != 4'd0) n++;
    end
    check("period0_all_low", n, 0);

    // Reset in the middle of a ramp.
    wr(4'd0, 32'd999);
    wr(4'd1, 32'd9);
    wr(4'd4, 32'd150);
    repeat (1010) @(negedge clk);
    rd(4'd0, 32'd999, "pre_reset_read");
    check("pre_reset_pwm3", 32'(pwm[3]), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midramp_reset_pwm", 32'(pwm), 32'd0);
    check("midramp_reset_readdata", s_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++)
      rd(4'(a), a == 3 ? 32'hF : 32'd0, "post_reset_reg");
    wr(4'd4, 32'd77);
    rd(4'd5, 32'd77, "post_reset_preload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
